// File: rtl/rs232_tx_serializer_if.sv
// 32-bit stb/ack word stream feeding the UART transmitter.
interface rs232_tx_serializer_if;
  logic [31:0] input_rs232_tx;
  logic        input_rs232_tx_stb;
  logic        input_rs232_tx_ack;

  modport master (
    output input_rs232_tx,
    output input_rs232_tx_stb,
    input  input_rs232_tx_ack
  );

  modport slave (
    input  input_rs232_tx,
    input  input_rs232_tx_stb,
    output input_rs232_tx_ack
  );
endinterface

// File: rtl/rs232_tx_serializer.sv
// 8N1 UART transmitter: accepts the low byte of a stream word, start bit on the cycle after transfer.
// ack is high only in IDLE, so a producer is held off for the whole 10-bit frame.
module rs232_tx_serializer #(
  parameter int unsigned CLOCK_FREQUENCY = 100000000,
  parameter int unsigned BAUD_RATE       = 115200
) (
  input  logic                        clk,
  input  logic                        rst,
  rs232_tx_serializer_if.slave        in_if,
  output logic                        tx
);
  localparam int unsigned CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned BAUD_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);

  generate
    if (CLOCKS_PER_BIT < 2) begin : g_cpb_check
      $error("rs232_tx_serializer: CLOCK_FREQUENCY/BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        data_q, data_d;
  logic              tx_q, tx_d;
  logic              ack_q, ack_d;
  logic              xfer;
  logic              bit_end;
  logic [23:0]       unused_upper;

  assign unused_upper = in_if.input_rs232_tx[31:8];
  assign xfer         = (state_q == S_IDLE) && ack_q && in_if.input_rs232_tx_stb;
  assign bit_end      = (baud_q == BAUD_LAST);

  // State register; tx and ack are registered copies of the next-state outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (xfer) begin
          data_d  = in_if.input_rs232_tx[7:0];
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs follow the next state, so tx only moves when state or bit index does.
  always_comb begin
    tx_d  = 1'b1;
    ack_d = 1'b0;
    case (state_d)
      S_IDLE:  begin tx_d = 1'b1; ack_d = 1'b1; end
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = data_d[bit_d];
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx                       = tx_q;
  assign in_if.input_rs232_tx_ack = ack_q;
endmodule

// File: tb/tb_rs232_tx_serializer.sv
// Directed bench for rs232_tx_serializer at 10 clocks per bit.
module tb_rs232_tx_serializer;
  logic clk = 1'b0;
  logic rst;
  logic tx;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   hs    = 0;
  int   hs0;
  int   t0;
  int   t1;

  rs232_tx_serializer_if bus();

  rs232_tx_serializer #(
    .CLOCK_FREQUENCY(1000),
    .BAUD_RATE      (100)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .in_if(bus.slave),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.input_rs232_tx_stb && bus.input_rs232_tx_ack) hs <= hs + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int bi;
    bi = k / 10;
    if (bi == 0) return 1'b0;
    if (bi >= 9) return 1'b1;
    return b[bi-1];
  endfunction

  // Waits for ack, then advances across the transfer edge (lands on start cycle 0).
  task automatic wait_xfer(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (bus.input_rs232_tx_ack === 1'b1) got = 1'b1;
      tick();
    end
    check({tag, "_handshake"}, 32'(got), 1);
  endtask

  task automatic frame(input string tag, input logic [7:0] b, input int hold_at,
                       input logic [31:0] hold_dat);
    for (int k = 0; k < 100; k++) begin
      check({tag, "_tx"}, 32'(tx), 32'(exp_tx(b, k)));
      check({tag, "_ack_busy"}, 32'(bus.input_rs232_tx_ack), 0);
      if (k == hold_at) begin
        bus.input_rs232_tx     = hold_dat;
        bus.input_rs232_tx_stb = 1'b1;
      end
      tick();
    end
    check({tag, "_ack_back"}, 32'(bus.input_rs232_tx_ack), 1);
    check({tag, "_tx_idle"}, 32'(tx), 1);
  endtask

  initial begin
    rst                    = 1'b1;
    bus.input_rs232_tx     = '0;
    bus.input_rs232_tx_stb = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_tx", 32'(tx), 1);
      check("rst_ack", 32'(bus.input_rs232_tx_ack), 0);
    end
    rst = 1'b0;
    tick();
    check("release_ack", 32'(bus.input_rs232_tx_ack), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_tx", 32'(tx), 1);
      check("idle_ack", 32'(bus.input_rs232_tx_ack), 1);
    end

    // Single word 0x55
    hs0 = hs;
    bus.input_rs232_tx     = 32'h0000_0055;
    bus.input_rs232_tx_stb = 1'b1;
    wait_xfer("w55");
    bus.input_rs232_tx_stb = 1'b0;
    frame("w55", 8'h55, -1, 0);
    check("w55_hs", 32'(hs - hs0), 1);

    // Upper bits ignored
    bus.input_rs232_tx     = 32'hABCD_EF0F;
    bus.input_rs232_tx_stb = 1'b1;
    wait_xfer("w0F");
    bus.input_rs232_tx_stb = 1'b0;
    frame("w0F", 8'h0F, -1, 0);

    // Back-to-back with stb held high
    hs0 = hs;
    bus.input_rs232_tx     = 32'h41;
    bus.input_rs232_tx_stb = 1'b1;
    wait_xfer("b41");
    t0 = cyc;
    bus.input_rs232_tx = 32'h42;
    frame("b41", 8'h41, -1, 0);
    tick();
    t1 = cyc;
    check("b2b_gap", 32'(t1 - t0), 101);
    bus.input_rs232_tx_stb = 1'b0;
    frame("b42", 8'h42, -1, 0);
    check("b2b_hs", 32'(hs - hs0), 2);
    tick();
    check("b2b_no_dup", 32'(hs - hs0), 2);

    // Producer asserts stb during the third data bit
    hs0 = hs;
    bus.input_rs232_tx     = 32'h10;
    bus.input_rs232_tx_stb = 1'b1;
    wait_xfer("h10");
    bus.input_rs232_tx_stb = 1'b0;
    frame("h10", 8'h10, 32, 32'h7E);
    check("hold_hs_pending", 32'(hs - hs0), 1);
    tick();
    bus.input_rs232_tx_stb = 1'b0;
    frame("h7E", 8'h7E, -1, 0);
    check("hold_hs", 32'(hs - hs0), 2);

    // Reset pulse in the middle of data bit 4
    bus.input_rs232_tx     = 32'h00;
    bus.input_rs232_tx_stb = 1'b1;
    wait_xfer("r00");
    bus.input_rs232_tx_stb = 1'b0;
    for (int i = 0; i < 54; i++) tick();
    check("mid_tx_low", 32'(tx), 0);
    rst = 1'b1;
    tick();
    check("mid_rst_tx", 32'(tx), 1);
    check("mid_rst_ack", 32'(bus.input_rs232_tx_ack), 0);
    rst = 1'b0;
    tick();
    check("mid_release_ack", 32'(bus.input_rs232_tx_ack), 1);
    check("mid_release_tx", 32'(tx), 1);
    for (int i = 0; i < 30; i++) begin
      tick();
      check("mid_no_resume", 32'(tx), 1);
    end
    bus.input_rs232_tx     = 32'hFF;
    bus.input_rs232_tx_stb = 1'b1;
    wait_xfer("wFF");
    bus.input_rs232_tx_stb = 1'b0;
    frame("wFF", 8'hFF, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
